// File: rtl/vector_issue_queue.sv
// Multi-entry vector instruction queue. It decodes the head entry into a
// one-hot unit-valid vector and runs the load/store handshakes with M_CU.
// An indexed load issues twice. Phase A sends the original word to unit 9.
// The head is then rewritten in place as a unit-stride load whose width
// field comes from the SEW captured at push. Phase B then follows the
// normal load path.
module vector_issue_queue #(
    parameter int DEPTH      = 4,
    parameter int NUM_UNITS  = 12,
    parameter int CFG_BUBBLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       instr_vld_i,
    input  logic [31:0]                vector_instr_i,
    input  logic [31:0]                rs1_i,
    input  logic [31:0]                rs2_i,
    input  logic [1:0]                 sew_i,
    output logic                       vector_stall_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    input  logic [NUM_UNITS-1:0]       unit_rdy_i,
    output logic [NUM_UNITS-1:0]       unit_vld_o,
    output logic [31:0]                vector_instr_o,
    output logic [31:0]                scalar_rs1_o,
    output logic [31:0]                scalar_rs2_o,
    output logic                       mcu_ld_vld_o,
    input  logic                       mcu_ld_rdy_i,
    input  logic                       mcu_ld_buffered_i,
    output logic                       mcu_st_vld_o,
    input  logic                       mcu_st_rdy_i,
    output logic [31:0]                mcu_base_addr_o,
    output logic [31:0]                mcu_stride_o,
    output logic [2:0]                 mcu_data_width_o,
    output logic                       mcu_unit_ld_st_o,
    output logic                       mcu_strided_ld_st_o,
    output logic                       mcu_idx_ld_st_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int BW = (CFG_BUBBLE > 0) ? $clog2(CFG_BUBBLE + 1) : 1;

    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   rs1_q   [DEPTH];
    logic [31:0]   rs2_q   [DEPTH];
    logic [1:0]    sew_q   [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ld_sent_q;
    logic [BW-1:0] bub_q;

    logic          head_vld, active, push, pop, fire, phase_a;
    logic [31:0]   head_instr, head_rw;
    logic [6:0]    opcode;
    logic [2:0]    funct3, new_w;
    logic [1:0]    mop;
    logic          f6_mul;
    logic          is_ld, is_st;
    logic [11:0]   unit_sel, unit_vld;

    assign head_vld   = (count_q != '0);
    assign active     = head_vld && (bub_q == '0);
    assign head_instr = instr_q[rd_ptr_q];
    assign opcode     = head_instr[6:0];
    assign funct3     = head_instr[14:12];
    assign mop        = head_instr[27:26];
    assign f6_mul     = (head_instr[31:29] == 3'b101);
    assign is_ld      = (opcode == 7'b0000111);
    assign is_st      = (opcode == 7'b0100111);

    // Decode the head entry into its target unit (zero when unmapped)
    always_comb begin
        unit_sel = '0;
        if (opcode == 7'b1010111) begin
            case (funct3)
                3'b000:  unit_sel[0] = 1'b1;
                3'b011:  unit_sel[1] = 1'b1;
                3'b100:  unit_sel[2] = 1'b1;
                3'b010:  unit_sel[f6_mul ? 5 : 3] = 1'b1;
                3'b110:  unit_sel[f6_mul ? 6 : 4] = 1'b1;
                3'b111:  unit_sel[7] = 1'b1;
                default: unit_sel = '0;
            endcase
        end else if (is_ld) begin
            unit_sel[mop[0] ? 9 : 8] = 1'b1;
        end else if (is_st) begin
            unit_sel[mop[0] ? 11 : 10] = 1'b1;
        end
    end

    // Gate the decoded unit by the M_CU conditions of its class
    always_comb begin
        unit_vld = '0;
        if (active) begin
            if (unit_sel[8])
                unit_vld[8] = ld_sent_q && mcu_ld_buffered_i;
            else if (unit_sel[10] || unit_sel[11])
                unit_vld = mcu_st_rdy_i ? unit_sel : '0;
            else
                unit_vld = unit_sel;
        end
    end

    // Width field for the phase B rewrite, taken from the SEW captured at push
    always_comb begin
        case (sew_q[rd_ptr_q])
            2'b00:   new_w = 3'b000;
            2'b01:   new_w = 3'b101;
            2'b10:   new_w = 3'b110;
            default: new_w = 3'b111;
        endcase
    end

    assign head_rw  = {head_instr[31:28], 2'b00, head_instr[25:15], new_w, head_instr[11:0]};
    assign fire     = |(unit_vld & unit_rdy_i[11:0]);
    assign phase_a  = fire && unit_sel[9];
    assign pop      = active && ((fire && !unit_sel[9]) || (unit_sel == '0));
    assign push     = instr_vld_i && (count_q != CW'(DEPTH));
    assign count_d  = count_q + CW'(push) - CW'(pop);

    // Entry storage: push at the tail, phase A rewrite at the head
    always_ff @(posedge clk) begin
        if (push) begin
            instr_q[wr_ptr_q] <= vector_instr_i;
            rs1_q[wr_ptr_q]   <= rs1_i;
            rs2_q[wr_ptr_q]   <= rs2_i;
            sew_q[wr_ptr_q]   <= sew_i;
        end
        if (phase_a)
            instr_q[rd_ptr_q] <= head_rw;
    end

    // Pointers, count, load-sent flag and post-OPCFG bubble counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ld_sent_q <= 1'b0;
            bub_q     <= '0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            if (pop)
                ld_sent_q <= 1'b0;
            else if (mcu_ld_vld_o && mcu_ld_rdy_i)
                ld_sent_q <= 1'b1;
            if (pop && unit_sel[7])
                bub_q <= BW'(CFG_BUBBLE);
            else if (bub_q != '0)
                bub_q <= bub_q - BW'(1);
        end
    end

    assign vector_stall_o      = (count_q == CW'(DEPTH));
    assign occupancy_o         = count_q;
    assign unit_vld_o          = NUM_UNITS'(unit_vld);
    assign mcu_ld_vld_o        = active && unit_sel[8] && !ld_sent_q;
    assign mcu_st_vld_o        = active && is_st;
    assign vector_instr_o      = head_vld ? head_instr : '0;
    assign scalar_rs1_o        = head_vld ? rs1_q[rd_ptr_q] : '0;
    assign scalar_rs2_o        = head_vld ? rs2_q[rd_ptr_q] : '0;
    assign mcu_base_addr_o     = scalar_rs1_o;
    assign mcu_stride_o        = scalar_rs2_o;
    assign mcu_data_width_o    = head_vld ? funct3 : '0;
    assign mcu_unit_ld_st_o    = head_vld && (mop == 2'b00);
    assign mcu_strided_ld_st_o = head_vld && (mop == 2'b10);
    assign mcu_idx_ld_st_o     = head_vld && (mop == 2'b01);
endmodule

// File: tb/tb_vector_issue_queue.sv
// Bench for vector_issue_queue: directed scenarios followed by randomized
// traffic checked against a queue-based reference model.
module tb_vector_issue_queue;
    localparam int DEPTH = 4;
    localparam int CFG_BUBBLE = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_vld_i;
    logic [31:0] vector_instr_i, rs1_i, rs2_i;
    logic [1:0]  sew_i;
    logic        vector_stall_o;
    logic [2:0]  occupancy_o;
    logic [11:0] unit_rdy_i, unit_vld_o;
    logic [31:0] vector_instr_o, scalar_rs1_o, scalar_rs2_o;
    logic        mcu_ld_vld_o, mcu_ld_rdy_i, mcu_ld_buffered_i;
    logic        mcu_st_vld_o, mcu_st_rdy_i;
    logic [31:0] mcu_base_addr_o, mcu_stride_o;
    logic [2:0]  mcu_data_width_o;
    logic        mcu_unit_ld_st_o, mcu_strided_ld_st_o, mcu_idx_ld_st_o;

    int n_cmp = 0;
    int n_err = 0;

    vector_issue_queue #(.DEPTH(DEPTH), .NUM_UNITS(12), .CFG_BUBBLE(CFG_BUBBLE)) dut (
        .clk(clk), .rst(rst), .instr_vld_i(instr_vld_i), .vector_instr_i(vector_instr_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .sew_i(sew_i), .vector_stall_o(vector_stall_o),
        .occupancy_o(occupancy_o), .unit_rdy_i(unit_rdy_i), .unit_vld_o(unit_vld_o),
        .vector_instr_o(vector_instr_o), .scalar_rs1_o(scalar_rs1_o), .scalar_rs2_o(scalar_rs2_o),
        .mcu_ld_vld_o(mcu_ld_vld_o), .mcu_ld_rdy_i(mcu_ld_rdy_i),
        .mcu_ld_buffered_i(mcu_ld_buffered_i), .mcu_st_vld_o(mcu_st_vld_o),
        .mcu_st_rdy_i(mcu_st_rdy_i), .mcu_base_addr_o(mcu_base_addr_o),
        .mcu_stride_o(mcu_stride_o), .mcu_data_width_o(mcu_data_width_o),
        .mcu_unit_ld_st_o(mcu_unit_ld_st_o), .mcu_strided_ld_st_o(mcu_strided_ld_st_o),
        .mcu_idx_ld_st_o(mcu_idx_ld_st_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [1:0]  sew;
    } ent_t;

    ent_t q[$];
    bit   m_sent;
    int   m_bub;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] mk_ar(input logic [5:0] f6, input logic [2:0] f3);
        return {f6, 1'b1, 5'd2, 5'd1, f3, 5'd3, 7'b1010111};
    endfunction

    function automatic logic [31:0] mk_ld(input logic [1:0] mop, input logic [2:0] w);
        return {3'b000, 1'b0, mop, 1'b1, 5'd0, 5'd10, w, 5'd4, 7'b0000111};
    endfunction

    function automatic logic [31:0] mk_st(input logic [1:0] mop, input logic [2:0] w);
        return {3'b000, 1'b0, mop, 1'b1, 5'd0, 5'd10, w, 5'd4, 7'b0100111};
    endfunction

    // Target unit of an instruction word, -1 when it maps to no unit
    function automatic int uidx(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3, f6h;
        op = w[6:0];
        f3 = w[14:12];
        f6h = w[31:29];
        if (op == 7'b1010111) begin
            case (f3)
                3'b000: return 0;
                3'b011: return 1;
                3'b100: return 2;
                3'b010: return (f6h == 3'b101) ? 5 : 3;
                3'b110: return (f6h == 3'b101) ? 6 : 4;
                3'b111: return 7;
                default: return -1;
            endcase
        end
        if (op == 7'b0000111) return w[26] ? 9 : 8;
        if (op == 7'b0100111) return w[26] ? 11 : 10;
        return -1;
    endfunction

    function automatic logic [31:0] rewr(input logic [31:0] w, input logic [1:0] s);
        logic [2:0] wd;
        case (s)
            2'b00:   wd = 3'b000;
            2'b01:   wd = 3'b101;
            2'b10:   wd = 3'b110;
            default: wd = 3'b111;
        endcase
        return {w[31:28], 2'b00, w[25:15], wd, w[11:0]};
    endfunction

    initial begin
        logic [31:0] idx_w;
        rst = 1'b1;
        instr_vld_i = 1'b0;
        vector_instr_i = '0;
        rs1_i = '0;
        rs2_i = '0;
        sew_i = '0;
        unit_rdy_i = '0;
        mcu_ld_rdy_i = 1'b0;
        mcu_ld_buffered_i = 1'b0;
        mcu_st_rdy_i = 1'b0;
        cyc();
        #1;
        chk("rst_occ", occupancy_o, 0);
        chk("rst_stall", vector_stall_o, 0);
        chk("rst_uvld", unit_vld_o, 0);
        chk("rst_ldvld", mcu_ld_vld_o, 0);
        chk("rst_stvld", mcu_st_vld_o, 0);
        chk("rst_instr", vector_instr_o, 0);
        rst = 1'b0;
        cyc();

        // Fill with vadd.vv while V_CU is not ready, then drain
        for (int i = 0; i < DEPTH; i++) begin
            instr_vld_i = 1'b1;
            vector_instr_i = mk_ar(6'd0, 3'b000);
            rs1_i = 32'(i);
            cyc();
        end
        vector_instr_i = mk_ar(6'd0, 3'b011);
        unit_rdy_i = 12'h001;
        #1;
        chk("full_stall", vector_stall_o, 1);
        chk("full_occ", occupancy_o, 4);
        chk("full_uvld", unit_vld_o, 12'h001);
        cyc();
        instr_vld_i = 1'b0;
        #1;
        chk("pop1_occ", occupancy_o, 3);
        chk("pop1_stall", vector_stall_o, 0);
        chk("pop1_rs1", scalar_rs1_o, 1);
        for (int i = 0; i < 3; i++) begin
            chk("drain_uvld", unit_vld_o, 12'h001);
            cyc();
            #1;
        end
        chk("drain_occ", occupancy_o, 0);
        chk("drain_uvld0", unit_vld_o, 0);
        unit_rdy_i = '0;

        // Unit-stride load handshake
        instr_vld_i = 1'b1;
        vector_instr_i = mk_ld(2'b00, 3'b000);
        rs1_i = 32'h1000;
        rs2_i = 32'h4;
        cyc();
        instr_vld_i = 1'b0;
        #1;
        chk("ld_c0_vld", mcu_ld_vld_o, 1);
        chk("ld_c0_uvld", unit_vld_o, 0);
        chk("ld_base", mcu_base_addr_o, 32'h1000);
        chk("ld_stride", mcu_stride_o, 32'h4);
        chk("ld_unitflag", mcu_unit_ld_st_o, 1);
        cyc();
        mcu_ld_buffered_i = 1'b1;
        #1;
        chk("ld_c1_vld", mcu_ld_vld_o, 1);
        chk("ld_early_buf", unit_vld_o, 0);
        cyc();
        mcu_ld_buffered_i = 1'b0;
        mcu_ld_rdy_i = 1'b1;
        #1;
        chk("ld_c2_vld", mcu_ld_vld_o, 1);
        cyc();
        mcu_ld_rdy_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ld_wait_vld", mcu_ld_vld_o, 0);
            chk("ld_wait_uvld", unit_vld_o, 0);
            cyc();
        end
        mcu_ld_buffered_i = 1'b1;
        #1;
        chk("ld_c5_uvld", unit_vld_o, 12'h100);
        cyc();
        unit_rdy_i = 12'h100;
        #1;
        chk("ld_c6_occ", occupancy_o, 1);
        cyc();
        unit_rdy_i = '0;
        mcu_ld_buffered_i = 1'b0;
        #1;
        chk("ld_pop_occ", occupancy_o, 0);
        chk("ld_pop_vld", mcu_ld_vld_o, 0);

        // Indexed load, two phases
        idx_w = mk_ld(2'b11, 3'b111);
        instr_vld_i = 1'b1;
        vector_instr_i = idx_w;
        sew_i = 2'b10;
        cyc();
        instr_vld_i = 1'b0;
        sew_i = 2'b00;
        #1;
        chk("idxA_uvld", unit_vld_o, 12'h200);
        chk("idxA_instr", vector_instr_o, idx_w);
        chk("idxA_ldvld", mcu_ld_vld_o, 0);
        unit_rdy_i = 12'h200;
        cyc();
        unit_rdy_i = '0;
        #1;
        chk("idxB_occ", occupancy_o, 1);
        chk("idxB_instr", vector_instr_o, {idx_w[31:28], 2'b00, idx_w[25:15], 3'b110, idx_w[11:0]});
        chk("idxB_width", mcu_data_width_o, 3'b110);
        chk("idxB_unitflag", mcu_unit_ld_st_o, 1);
        chk("idxB_ldvld", mcu_ld_vld_o, 1);
        chk("idxB_uvld0", unit_vld_o, 0);
        mcu_ld_rdy_i = 1'b1;
        cyc();
        mcu_ld_rdy_i = 1'b0;
        mcu_ld_buffered_i = 1'b1;
        unit_rdy_i = 12'h100;
        #1;
        chk("idxB_uvld", unit_vld_o, 12'h100);
        chk("idxB_occ2", occupancy_o, 1);
        cyc();
        mcu_ld_buffered_i = 1'b0;
        unit_rdy_i = '0;
        #1;
        chk("idx_pop_occ", occupancy_o, 0);

        // Store waits on mcu_st_rdy_i
        instr_vld_i = 1'b1;
        vector_instr_i = mk_st(2'b00, 3'b010);
        cyc();
        instr_vld_i = 1'b0;
        unit_rdy_i = 12'h400;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("st_wait_vld", mcu_st_vld_o, 1);
            chk("st_wait_uvld", unit_vld_o, 0);
            chk("st_wait_occ", occupancy_o, 1);
            cyc();
        end
        mcu_st_rdy_i = 1'b1;
        #1;
        chk("st_uvld", unit_vld_o, 12'h400);
        cyc();
        mcu_st_rdy_i = 1'b0;
        unit_rdy_i = '0;
        #1;
        chk("st_pop_occ", occupancy_o, 0);
        chk("st_pop_vld", mcu_st_vld_o, 0);

        // vsetvli then vle: one bubble cycle after the OPCFG pop
        instr_vld_i = 1'b1;
        vector_instr_i = mk_ar(6'd0, 3'b111);
        cyc();
        vector_instr_i = mk_ld(2'b00, 3'b000);
        cyc();
        instr_vld_i = 1'b0;
        unit_rdy_i = 12'hFFF;
        #1;
        chk("cfg_uvld", unit_vld_o, 12'h080);
        chk("cfg_occ", occupancy_o, 2);
        cyc();
        #1;
        chk("bub_uvld", unit_vld_o, 0);
        chk("bub_ldvld", mcu_ld_vld_o, 0);
        chk("bub_occ", occupancy_o, 1);
        cyc();
        #1;
        chk("postbub_ldvld", mcu_ld_vld_o, 1);
        mcu_ld_rdy_i = 1'b1;
        cyc();
        mcu_ld_rdy_i = 1'b0;
        mcu_ld_buffered_i = 1'b1;
        #1;
        chk("postbub_uvld", unit_vld_o, 12'h100);
        cyc();
        mcu_ld_buffered_i = 1'b0;
        unit_rdy_i = '0;
        #1;
        chk("postbub_occ", occupancy_o, 0);

        // Unmapped FP instruction drops after one cycle at head
        instr_vld_i = 1'b1;
        vector_instr_i = mk_ar(6'd0, 3'b001);
        cyc();
        instr_vld_i = 1'b0;
        #1;
        chk("fp_uvld", unit_vld_o, 0);
        chk("fp_occ", occupancy_o, 1);
        cyc();
        #1;
        chk("fp_pop_occ", occupancy_o, 0);

        // Reset mid-operation with ld_sent set
        for (int i = 0; i < 3; i++) begin
            instr_vld_i = 1'b1;
            vector_instr_i = mk_ld(2'b00, 3'b000);
            cyc();
        end
        instr_vld_i = 1'b0;
        #1;
        chk("rm_occ3", occupancy_o, 3);
        chk("rm_ldvld", mcu_ld_vld_o, 1);
        mcu_ld_rdy_i = 1'b1;
        cyc();
        mcu_ld_rdy_i = 1'b0;
        #1;
        chk("rm_sent", mcu_ld_vld_o, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("rm_occ0", occupancy_o, 0);
        chk("rm_uvld", unit_vld_o, 0);
        chk("rm_ldvld0", mcu_ld_vld_o, 0);
        chk("rm_stvld0", mcu_st_vld_o, 0);
        chk("rm_stall", vector_stall_o, 0);
        instr_vld_i = 1'b1;
        vector_instr_i = mk_ld(2'b00, 3'b000);
        cyc();
        instr_vld_i = 1'b0;
        #1;
        chk("rm_rereq", mcu_ld_vld_o, 1);
        chk("rm_occ1", occupancy_o, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;

        // Randomized traffic against the reference model
        q.delete();
        m_sent = 0;
        m_bub = 0;
        for (int c = 0; c < 1500; c++) begin
            int r, ix;
            bit act, ok, eld, est, fire, push_ok;
            logic [11:0] ev;
            ent_t e, h;
            r = $urandom_range(0, 9);
            e.instr = $urandom();
            if (r < 5) e.instr[6:0] = 7'b1010111;
            else if (r < 7) e.instr[6:0] = 7'b0000111;
            else if (r < 9) e.instr[6:0] = 7'b0100111;
            e.rs1 = $urandom();
            e.rs2 = $urandom();
            e.sew = 2'($urandom());
            instr_vld_i = ($urandom_range(0, 1) == 1);
            vector_instr_i = e.instr;
            rs1_i = e.rs1;
            rs2_i = e.rs2;
            sew_i = e.sew;
            unit_rdy_i = 12'($urandom()) | 12'($urandom());
            mcu_ld_rdy_i = ($urandom_range(0, 2) == 0);
            mcu_ld_buffered_i = ($urandom_range(0, 1) == 1);
            mcu_st_rdy_i = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 99) == 0);
            #1;
            act = (q.size() != 0) && (m_bub == 0);
            ix = (q.size() != 0) ? uidx(q[0].instr) : -1;
            ev = '0;
            if (act && ix >= 0) begin
                if (ix == 8) ok = m_sent && mcu_ld_buffered_i;
                else if (ix >= 10) ok = mcu_st_rdy_i;
                else ok = 1;
                if (ok) ev[ix] = 1'b1;
            end
            eld = act && (ix == 8) && !m_sent;
            est = act && (ix >= 10);
            chk("rnd_uvld", unit_vld_o, ev);
            chk("rnd_ldvld", mcu_ld_vld_o, eld);
            chk("rnd_stvld", mcu_st_vld_o, est);
            chk("rnd_occ", occupancy_o, q.size());
            chk("rnd_stall", vector_stall_o, q.size() == DEPTH);
            chk("rnd_instr", vector_instr_o, (q.size() != 0) ? q[0].instr : 32'h0);
            chk("rnd_rs1", mcu_base_addr_o, (q.size() != 0) ? q[0].rs1 : 32'h0);
            chk("rnd_rs2", scalar_rs2_o, (q.size() != 0) ? q[0].rs2 : 32'h0);
            chk("rnd_width", mcu_data_width_o, (q.size() != 0) ? q[0].instr[14:12] : 3'b000);
            chk("rnd_strided", mcu_strided_ld_st_o, (q.size() != 0) && (q[0].instr[27:26] == 2'b10));
            chk("rnd_idx", mcu_idx_ld_st_o, (q.size() != 0) && (q[0].instr[27:26] == 2'b01));
            if (rst) begin
                q.delete();
                m_sent = 0;
                m_bub = 0;
            end else begin
                fire = ((ev & unit_rdy_i) != 0);
                push_ok = instr_vld_i && (q.size() < DEPTH);
                if (eld && mcu_ld_rdy_i) m_sent = 1;
                if (m_bub > 0) m_bub--;
                if (fire && ix == 9) begin
                    h = q[0];
                    h.instr = rewr(h.instr, h.sew);
                    q[0] = h;
                end else if (act && (fire || ix < 0)) begin
                    void'(q.pop_front());
                    m_sent = 0;
                    if (ix == 7) m_bub = CFG_BUBBLE;
                end
                if (push_ok) q.push_back(e);
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
